// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage pipelined IEEE-754 style adder/subtractor with valid/ready handshake.
// Build option: define FP_ADD_RNE_EN for round-to-nearest-even; otherwise truncate toward zero.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int XLEN = 1 + EXP_W + MAN_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            op_sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            overflow,
    output logic            underflow,
    output logic            exception
);
    // Extended mantissa: {hidden, fraction, guard, round, sticky}; the sum adds a carry bit.
    localparam int FW  = MAN_W + 4;
    localparam int SW  = MAN_W + 5;
    localparam int LZW = $clog2(FW + 1);
    localparam int EW  = EXP_W + LZW + 2;
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [EW-1:0] EXP_OVF  = $signed({{(EW-EXP_W){1'b0}}, EXP_ONES});
    localparam logic signed [EW-1:0] E_ONE    = EW'(1);
    localparam logic [XLEN-1:0]      QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    logic stall;
    logic adv;

    assign stall    = out_valid & ~out_ready;
    assign adv      = ~stall;
    assign in_ready = ~stall;

    // ---------------- S1: unpack, swap, align ----------------
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_nan, b_nan, a_inf, b_inf;
    logic [FW-1:0]    ext_a, ext_b;
    logic             a_big;
    logic [EXP_W-1:0] e_big, e_dif;
    logic [FW-1:0]    x_big, x_small, x_align;
    logic [2*FW-1:0]  x_shift;

    always_comb begin
        sa    = a[XLEN-1];
        sb    = b[XLEN-1] ^ op_sub;
        ea    = a[XLEN-2:MAN_W];
        eb    = b[XLEN-2:MAN_W];
        ma    = a[MAN_W-1:0];
        mb    = b[MAN_W-1:0];
        a_nan = (ea == EXP_ONES) && (ma != '0);
        b_nan = (eb == EXP_ONES) && (mb != '0);
        a_inf = (ea == EXP_ONES) && (ma == '0);
        b_inf = (eb == EXP_ONES) && (mb == '0);
        // exp==0 covers zero and subnormal alike: both become a signed zero
        ext_a = (ea == '0) ? '0 : {1'b1, ma, 3'b000};
        ext_b = (eb == '0) ? '0 : {1'b1, mb, 3'b000};
        a_big   = {ea, ext_a} >= {eb, ext_b};
        e_big   = a_big ? ea : eb;
        e_dif   = a_big ? (ea - eb) : (eb - ea);
        x_big   = a_big ? ext_a : ext_b;
        x_small = a_big ? ext_b : ext_a;
        x_shift = {x_small, {FW{1'b0}}} >> e_dif;
        if (32'(e_dif) >= 32'(MAN_W + 3))
            x_align = {{(FW-1){1'b0}}, |x_small};
        else
            x_align = x_shift[2*FW-1:FW] | {{(FW-1){1'b0}}, |x_shift[FW-1:0]};
    end

    logic             s1_valid, s1_sign, s1_sub, s1_nan, s1_inf, s1_inf_sign, s1_zero_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [FW-1:0]    s1_big, s1_small;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_sign      <= 1'b0;
            s1_sub       <= 1'b0;
            s1_nan       <= 1'b0;
            s1_inf       <= 1'b0;
            s1_inf_sign  <= 1'b0;
            s1_zero_sign <= 1'b0;
            s1_exp       <= '0;
            s1_big       <= '0;
            s1_small     <= '0;
        end else if (adv) begin
            s1_valid     <= in_valid;
            s1_sign      <= a_big ? sa : sb;
            s1_sub       <= sa ^ sb;
            s1_nan       <= a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
            s1_inf       <= a_inf | b_inf;
            s1_inf_sign  <= a_inf ? sa : sb;
            s1_zero_sign <= sa & sb;
            s1_exp       <= e_big;
            s1_big       <= x_big;
            s1_small     <= x_align;
        end
    end

    // ---------------- S2: magnitude add/subtract ----------------
    logic [SW-1:0] sum_next;

    assign sum_next = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                             : ({1'b0, s1_big} + {1'b0, s1_small});

    logic             s2_valid, s2_sign, s2_nan, s2_inf, s2_inf_sign, s2_zero_sign;
    logic [EXP_W-1:0] s2_exp;
    logic [SW-1:0]    s2_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            s2_sign      <= 1'b0;
            s2_nan       <= 1'b0;
            s2_inf       <= 1'b0;
            s2_inf_sign  <= 1'b0;
            s2_zero_sign <= 1'b0;
            s2_exp       <= '0;
            s2_sum       <= '0;
        end else if (adv) begin
            s2_valid     <= s1_valid;
            s2_sign      <= s1_sign;
            s2_nan       <= s1_nan;
            s2_inf       <= s1_inf;
            s2_inf_sign  <= s1_inf_sign;
            s2_zero_sign <= s1_zero_sign;
            s2_exp       <= s1_exp;
            s2_sum       <= sum_next;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZW-1:0]         lzc;
    logic                   found;
    logic signed [EW-1:0]   e_base, lz_s, e_norm, e_fin;
    logic [FW-1:0]          x_norm;
    logic [MAN_W:0]         mant;
    logic [MAN_W+1:0]       mant_rnd;
    logic [MAN_W-1:0]       frac;
    logic                   rnd_inc, is_zero;
    logic [XLEN-1:0]        res_next;
    logic                   ovf_next, unf_next, exc_next;

    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int i = FW - 1; i >= 0; i--) begin
            if (!found && s2_sum[i]) begin
                found = 1'b1;
                lzc   = LZW'(FW - 1 - i);
            end
        end
        e_base = $signed({{(EW-EXP_W){1'b0}}, s2_exp});
        lz_s   = $signed({{(EW-LZW){1'b0}}, lzc});
        if (s2_sum[SW-1]) begin
            x_norm = s2_sum[SW-1:1] | {{(FW-1){1'b0}}, s2_sum[0]};
            e_norm = e_base + E_ONE;
        end else begin
            x_norm = s2_sum[FW-1:0] << lzc;
            e_norm = e_base - lz_s;
        end
        is_zero = ~|x_norm;
        mant    = x_norm[FW-1:3];
`ifdef FP_ADD_RNE_EN
        rnd_inc = x_norm[2] & (x_norm[1] | x_norm[0] | x_norm[3]);
`else
        rnd_inc = 1'b0;
`endif
        mant_rnd = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd_inc};
        // rounding past all-ones gives 10.00..0: bump exponent, fraction is zero
        if (mant_rnd[MAN_W+1]) begin
            e_fin = e_norm + E_ONE;
            frac  = mant_rnd[MAN_W:1];
        end else begin
            e_fin = e_norm;
            frac  = mant_rnd[MAN_W-1:0];
        end

        res_next = {s2_sign, e_fin[EXP_W-1:0], frac};
        ovf_next = 1'b0;
        unf_next = 1'b0;
        exc_next = 1'b0;
        if (s2_nan) begin
            res_next = QNAN;
            exc_next = 1'b1;
        end else if (s2_inf) begin
            res_next = {s2_inf_sign, EXP_ONES, {MAN_W{1'b0}}};
            exc_next = 1'b1;
        end else if (is_zero) begin
            res_next = {s2_zero_sign, {(XLEN-1){1'b0}}};
        end else if (e_fin >= EXP_OVF) begin
            res_next = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            ovf_next = 1'b1;
        end else if (e_fin < E_ONE) begin
            res_next = {s2_sign, {(XLEN-1){1'b0}}};
            unf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            exception <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            result    <= res_next;
            overflow  <= s2_valid & ovf_next;
            underflow <= s2_valid & unf_next;
            exception <= s2_valid & exc_next;
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Testbench for fp_add_pipe: vector table through a scoreboard, plus stall, latency and reset sequences.
`timescale 1ns/1ps
module tb_fp_add_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        op_sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, overflow, underflow, exception;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;

    always #5 clk = ~clk;

    fp_add_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .exception (exception)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        exc;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        exc;
        int          id;
    } exp_t;

`ifdef FP_ADD_RNE_EN
    localparam logic RNE = 1'b1;
`else
    localparam logic RNE = 1'b0;
`endif

    localparam int NV = 21;
    vec_t vecs[NV];
    exp_t sb_q[$];
    int   next_id = 0;

    function automatic vec_t mk(input logic [31:0] av, input logic [31:0] bv, input logic sub,
                                input logic [31:0] r, input logic o, input logic u, input logic x);
        vec_t v;
        v.a = av; v.b = bv; v.sub = sub; v.res = r; v.ovf = o; v.unf = u; v.exc = x;
        return v;
    endfunction

    // Present one operand pair; the expectation is queued once in_ready guarantees acceptance.
    task automatic send(input vec_t v);
        int   guard;
        exp_t e;
        guard    = 0;
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        op_sub   = v.sub;
        @(negedge clk);
        while (in_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, guard);
        end else begin
            e.res = v.res; e.ovf = v.ovf; e.unf = v.unf; e.exc = v.exc; e.id = next_id;
            next_id++;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, want 0", sb_q.size());
        end
    endtask

    task automatic latency_check(input vec_t v, input string tag);
        int cyc;
        send(v);
        cyc = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL %s: out_valid after %0d cycles, want 3", tag, cyc);
        end
    endtask

    // Output monitor: scoreboard compare on transfer, hold/backpressure checks on stall.
    logic        stall_prev = 1'b0;
    logic [31:0] held_res;
    logic [2:0]  held_flags;
    exp_t        got;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checks++;
                    if (out_valid !== 1'b1 || result !== held_res ||
                        {overflow, underflow, exception} !== held_flags) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%b result=%08h flags=%b, want valid=1 result=%08h flags=%b",
                                 out_valid, result, {overflow, underflow, exception}, held_res, held_flags);
                    end
                end
                if (out_valid === 1'b1 && out_ready === 1'b0) begin
                    stall_cnt++;
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_in_ready: in_ready=%b, want 0", in_ready);
                    end
                    stall_prev = 1'b1;
                    held_res   = result;
                    held_flags = {overflow, underflow, exception};
                end else begin
                    stall_prev = 1'b0;
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: result=%08h, want no output", result);
                    end else begin
                        got = sb_q.pop_front();
                        if (result !== got.res || overflow !== got.ovf ||
                            underflow !== got.unf || exception !== got.exc) begin
                            errors++;
                            $display("FAIL txn%0d: result=%08h ovf=%b unf=%b exc=%b, want result=%08h ovf=%b unf=%b exc=%b",
                                     got.id, result, overflow, underflow, exception,
                                     got.res, got.ovf, got.unf, got.exc);
                        end else begin
                            $display("txn%0d: result=%08h ovf=%b unf=%b exc=%b ok",
                                     got.id, result, overflow, underflow, exception);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(32'hBD900001, 32'h3DC00000, 1'b0, 32'h3CBFFFFC, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(32'h40400000, 32'h40400000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b1);
        vecs[5]  = mk(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b1);
        vecs[6]  = mk(32'h3F800000, 32'h33800001, 1'b0, RNE ? 32'h3F800001 : 32'h3F800000, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0, 1'b1);
        vecs[11] = mk(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0);
        vecs[12] = mk(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(32'h3FC00000, 32'h40200000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b0, 1'b0, 1'b1);
        vecs[16] = mk(32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0, 1'b0, 1'b1);
        vecs[17] = mk(32'h7F000000, 32'h7F000000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1'b0);
        vecs[18] = mk(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 1'b0, 1'b0, 1'b0);
        vecs[19] = mk(32'h4B800000, 32'h40400000, 1'b0, RNE ? 32'h4B800002 : 32'h4B800001, 1'b0, 1'b0, 1'b0);
        vecs[20] = mk(32'h3FFFFFFF, 32'h33800000, 1'b0, RNE ? 32'h40000000 : 32'h3FFFFFFF, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %08h, want 00000000", result); end
        if ({overflow, underflow, exception} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b, want 000", {overflow, underflow, exception});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors, back to back
        for (int i = 0; i < NV; i++) send(vecs[i]);
        drain();

        latency_check(vecs[1], "latency");
        drain();

        // 8 back-to-back ops with out_ready low for cycles 4-7
        stall_cnt = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(vecs[i]);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (stall_cnt < 4) begin
            errors++;
            $display("FAIL stall_seen: %0d stalled cycles observed, want >= 4", stall_cnt);
        end

        // Asynchronous reset with ops in flight
        send(vecs[13]);
        send(vecs[14]);
        send(vecs[9]);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b, want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks += 2;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b, want 0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_in_ready: got %b, want 1", in_ready); end
        sb_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_output: out_valid=%b result=%08h, want out_valid=0", out_valid, result);
            end
        end
        @(posedge clk);
        #1;
        latency_check(vecs[13], "latency_after_reset");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
